avg_pipe_arbiter: RTL

//  Shares one three-stage (a+b+c)/3 averaging pipeline between N requesters.
//  - Round-robin arbitration; at most one triple is issued per cycle.
//  - A tag travels alongside the data so each result returns with the owner's ID.
//  - Sits between requester agents and the pipeline, which has no stall or enable.
//  - Once a triple is issued it always completes; no responses are back-pressured.

---
 rtl/avg_pipe_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/avg_pipe_arbiter.sv
// rtl/avg_pipe_arbiter.sv - round-robin front end sharing one (a+b+c)/3 pipeline among N requesters
// Result ownership rides a tag shift register aligned with the fixed pipeline latency.
module avg_pipe_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int LAT   = 3,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ*W-1:0] req_c,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               hold,
  output logic [W-1:0]       pipe_a,
  output logic [W-1:0]       pipe_b,
  output logic [W-1:0]       pipe_c,
  input  logic [W-1:0]       pipe_avg,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [W-1:0]       rsp_avg,
  output logic [15:0]        issue_cnt
);

  logic [W-1:0]  r_pipe_a;
  logic [W-1:0]  r_pipe_b;
  logic [W-1:0]  r_pipe_c;
  logic [15:0]   r_issue_cnt;
  logic [IW-1:0] r_rr_ptr;
  // Stage 0 is loaded alongside pipe_*, so stage LAT lines up with pipe_avg.
  logic [LAT:0]  r_tag_v;
  logic [IW-1:0] r_tag_id [0:LAT];

  logic          w_found;
  logic [IW-1:0] w_gnt_idx;
  logic          w_xfer;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + off) % N_REQ]) begin
        w_found   = 1'b1;
        w_gnt_idx = IW'((int'(r_rr_ptr) + off) % N_REQ);
      end
    end
  end

  assign w_xfer    = w_found & ~hold;
  assign req_ready = w_xfer ? (N_REQ'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_a    <= '0;
      r_pipe_b    <= '0;
      r_pipe_c    <= '0;
      r_issue_cnt <= '0;
      r_rr_ptr    <= IW'(N_REQ - 1);
      r_tag_v     <= '0;
      for (int s = 0; s <= LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_pipe_a    <= req_a[int'(w_gnt_idx)*W +: W];
        r_pipe_b    <= req_b[int'(w_gnt_idx)*W +: W];
        r_pipe_c    <= req_c[int'(w_gnt_idx)*W +: W];
        r_issue_cnt <= r_issue_cnt + 16'd1;
        r_rr_ptr    <= w_gnt_idx;
      end
      r_tag_v     <= {r_tag_v[LAT-1:0], w_xfer};
      r_tag_id[0] <= w_xfer ? w_gnt_idx : '0;
      for (int s = 1; s <= LAT; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  assign pipe_a    = r_pipe_a;
  assign pipe_b    = r_pipe_b;
  assign pipe_c    = r_pipe_c;
  assign rsp_valid = r_tag_v[LAT];
  assign rsp_id    = r_tag_id[LAT];
  assign rsp_avg   = pipe_avg;
  assign issue_cnt = r_issue_cnt;

endmodule
